rti_req_arbiter: RTL and testbench
==================================

// Module: rti_req_arbiter
// PURPOSE
//  Shares one non-pipelined plane_ray_int intersection unit among NUM_REQ ray requesters.
//  Round-robin picks a requester, latches its 15-word FPRTI bundle, pulses the unit, waits for output_valid,
//  and returns the 32-bit result to that requester. Watchdog timeout returns an error word if the unit hangs.
//  Sits between the ray-dispatch queues and the plane_ray_int instance; exactly one operation in flight.
// PARAMETERS
//  NUM_REQ          3     number of requesters (2..8)
//  NUM_FPRTI_REGS   15    words per bundle: tri[0:8], origin[9:11], dir[12:14]
//  TIMEOUT_CYCLES   64    max WAIT cycles before forced error response (>=2)
// PORTS
//  clk            in   1                          clock, all logic on posedge
//  rst            in   1                          asynchronous, active-high reset
//  req_valid_i    in   NUM_REQ                    requester r has a bundle ready
//  req_ready_o    out  NUM_REQ                    one-hot accept; bundle taken when valid&ready
//  req_regs_i     in   [NUM_REQ][NUM_FPRTI_REGS] x32  per-requester operand bundle
//  resp_valid_o   out  NUM_REQ                    one-hot: result available for requester r
//  resp_ready_i   in   NUM_REQ                    requester r consumes result
//  resp_data_o    out  32                         result word (unit return_o or 32'hFFFF_FFFF on timeout)
//  resp_err_o     out  1                          1 = timeout response
//  unit_regs_o    out  [NUM_FPRTI_REGS] x32       to plane_ray_int fprti_regs_i
//  unit_valid_o   out  1                          to plane_ray_int input_valid_i
//  unit_result_i  in   32                         from plane_ray_int return_o
//  unit_done_i    in   1                          from plane_ray_int output_valid_o
//  busy_o         out  1                          state != IDLE
//  timeout_cnt_o  out  16                         saturating count of timeouts
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=NUM_REQ-1, all outputs 0 (unit_regs_o, resp_data_o, counters cleared).
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: if any req_valid_i, grant g = first valid scanning rr_ptr+1, +2, ... (mod NUM_REQ);
//   req_ready_o[g]=1 combinationally this cycle only; latch req_regs_i[g] into unit_regs_o, store g; -> ISSUE.
//   req_ready_o is 0 in every other state. No valid -> stay IDLE.
//  ISSUE: unit_valid_o=1 for exactly this one cycle; timer<=0; -> WAIT. unit_done_i ignored here.
//  WAIT: unit_done_i=1 -> resp_data<=unit_result_i, resp_err<=0, -> RESP.
//   else if timer==TIMEOUT_CYCLES-1 -> resp_data<=32'hFFFF_FFFF, resp_err<=1, timeout_cnt_o++ (sat 16'hFFFF), -> RESP.
//   else timer++. done and last-timer-cycle together: done wins (no error).
//  RESP: resp_valid_o[g]=1, resp_data_o/resp_err_o stable until resp_ready_i[g]=1; then rr_ptr<=g, -> IDLE.
//   resp_ready_i of non-granted requesters ignored.
//  unit_regs_o holds latched bundle from grant until next grant (unit may sample any time in WAIT).
//  unit_done_i in IDLE/RESP (stray/late after timeout) ignored, no state change.
//  Latency: accept cycle T -> unit_valid_o at T+1 -> resp_valid_o at T+3+L for unit latency L (done at T+2+L).
//  Min gap between successive grants: 1 IDLE cycle after response handshake.
//  Reset asserted in any state: immediate return to reset values; in-flight request dropped, no response.
//  rr_ptr updates only on completed response, so a reset-aborted grant does not advance fairness.
// TESTING
//  Single req: req_valid_i=3'b010, bundle of tri hitting ray, unit model L=4 returns 1 -> req_ready_o=010 one cycle,
//   unit_valid_o one pulse, resp_valid_o=010 with resp_data_o=1, resp_err_o=0, 7 cycles after accept.
//  Fairness: req_valid_i=3'b111 held, resp_ready_i=111 -> grant order 0,1,2,0,1,2; each bundle reaches unit_regs_o intact.
//  Backpressure: resp_ready_i[g]=0 for 10 cycles -> resp_valid_o/resp_data_o stable, no new req_ready_o until release.
//  Timeout: unit model never asserts done, TIMEOUT_CYCLES=64 -> resp_data_o=32'hFFFF_FFFF, resp_err_o=1,
//   timeout_cnt_o=1; late unit_done_i in IDLE ignored; next request completes normally.
//  Reset mid-WAIT: assert rst during WAIT -> busy_o=0, resp_valid_o=0, unit_valid_o=0 immediately; after release
//   req_valid_i=001 granted to requester 0 (rr_ptr reset).
//  Random: 100 DPI-generated triangle/ray cases over 3 requesters vs golden model -> every result matches, 0 errors.

Source files
------------

// File: rtl/rti_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rti_req_arbiter
// Brief    : Round-robin sharing of one plane_ray_int unit with a watchdog.
// Revision : 1.0
// ============================================================================
module rti_req_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int NUM_FPRTI_REGS = 15,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_REQ-1:0]                          req_valid_i,
    output logic [NUM_REQ-1:0]                          req_ready_o,
    input  logic [NUM_REQ-1:0][NUM_FPRTI_REGS-1:0][31:0] req_regs_i,
    output logic [NUM_REQ-1:0]                          resp_valid_o,
    input  logic [NUM_REQ-1:0]                          resp_ready_i,
    output logic [31:0]                                 resp_data_o,
    output logic                                        resp_err_o,
    output logic [NUM_FPRTI_REGS-1:0][31:0]             unit_regs_o,
    output logic                                        unit_valid_o,
    input  logic [31:0]                                 unit_result_i,
    input  logic                                        unit_done_i,
    output logic                                        busy_o,
    output logic [15:0]                                 timeout_cnt_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                             state_q;
    logic [IDX_W-1:0]                   rr_ptr_q;
    logic [IDX_W-1:0]                   grant_q;
    logic [TMR_W-1:0]                   timer_q;
    logic [NUM_FPRTI_REGS-1:0][31:0]    unit_regs_q;
    logic [31:0]                        resp_data_q;
    logic                               resp_err_q;
    logic [15:0]                        timeout_cnt_q;

    logic [IDX_W-1:0]                   grant_d;
    logic                               grant_vld_d;
    logic [IDX_W-1:0]                   scan_idx;

    // Scan starts one past the last served requester so the most recent winner goes last.
    always_comb begin
        grant_d     = '0;
        grant_vld_d = 1'b0;
        scan_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_vld_d && req_valid_i[scan_idx]) begin
                grant_vld_d = 1'b1;
                grant_d     = scan_idx;
            end
        end
    end

    assign req_ready_o   = (state_q == S_IDLE && grant_vld_d) ? (NUM_REQ'(1) << grant_d) : '0;
    assign resp_valid_o  = (state_q == S_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign unit_valid_o  = (state_q == S_ISSUE);
    assign busy_o        = (state_q != S_IDLE);
    assign unit_regs_o   = unit_regs_q;
    assign resp_data_o   = resp_data_q;
    assign resp_err_o    = resp_err_q;
    assign timeout_cnt_o = timeout_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
            grant_q       <= '0;
            timer_q       <= '0;
            unit_regs_q   <= '0;
            resp_data_q   <= '0;
            resp_err_q    <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_vld_d) begin
                        grant_q     <= grant_d;
                        unit_regs_q <= req_regs_i[grant_d];
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the final watchdog cycle still counts as success.
                    if (unit_done_i) begin
                        resp_data_q <= unit_result_i;
                        resp_err_q  <= 1'b0;
                        state_q     <= S_RESP;
                    end else if (timer_q == C_TMR_LAST) begin
                        resp_data_q <= 32'hFFFF_FFFF;
                        resp_err_q  <= 1'b1;
                        if (timeout_cnt_q != 16'hFFFF) begin
                            timeout_cnt_q <= timeout_cnt_q + 16'd1;
                        end
                        state_q     <= S_RESP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready_i[grant_q]) begin
                        rr_ptr_q <= grant_q;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rti_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rti_req_arbiter
// Brief    : Randomized self-checking bench with a timeline-based reference model.
// Revision : 1.0
// ============================================================================
module tb_rti_req_arbiter;

    localparam int NR    = 3;
    localparam int NW    = 15;
    localparam int TO    = 64;
    localparam int NEVER = 10000;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NR-1:0]              req_valid_i;
    logic [NR-1:0]              req_ready_o;
    logic [NR-1:0][NW-1:0][31:0] req_regs_i;
    logic [NR-1:0]              resp_valid_o;
    logic [NR-1:0]              resp_ready_i;
    logic [31:0]                resp_data_o;
    logic                       resp_err_o;
    logic [NW-1:0][31:0]        unit_regs_o;
    logic                       unit_valid_o;
    logic [31:0]                unit_result_i;
    logic                       unit_done_i;
    logic                       busy_o;
    logic [15:0]                timeout_cnt_o;

    always #5 clk = ~clk;

    rti_req_arbiter #(
        .NUM_REQ        (NR),
        .NUM_FPRTI_REGS (NW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_regs_i    (req_regs_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_data_o   (resp_data_o),
        .resp_err_o    (resp_err_o),
        .unit_regs_o   (unit_regs_o),
        .unit_valid_o  (unit_valid_o),
        .unit_result_i (unit_result_i),
        .unit_done_i   (unit_done_i),
        .busy_o        (busy_o),
        .timeout_cnt_o (timeout_cnt_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one transaction described by its accept cycle and unit latency.
    int                  cyc;
    bit                  m_busy;
    int                  m_g, m_T, m_L, m_R, m_rr, m_free, m_tcnt, n_txn;
    logic [NW-1:0][31:0] m_bundle;
    logic [31:0]         m_data;
    bit                  m_err;

    // Requester / environment state
    bit                  act [NR];
    logic [NW-1:0][31:0] rq_b [NR];
    bit [NR-1:0]         arm_mask;
    int                  arm_pct, rdy_pct, lat_force;
    bit                  stray;
    int                  dut_log [$];
    int                  dut_acc_cyc, dut_resp_cyc;
    bit                  prev_rv;

    function automatic logic [31:0] unit_fn(input logic [NW-1:0][31:0] b);
        logic [31:0] s;
        s = 32'h1;
        for (int i = 0; i < NW; i++) s = {s[26:0], s[31:27]} ^ b[i];
        return s;
    endfunction

    function automatic int pick_lat();
        int r;
        if (lat_force >= 0) return lat_force;
        r = $urandom_range(0, 19);
        if (r == 0) return TO - 1;
        if (r == 1) return NEVER;
        return $urandom_range(0, 8);
    endfunction

    function automatic bit any_act();
        bit a;
        a = 1'b0;
        for (int r = 0; r < NR; r++) a |= act[r];
        return a;
    endfunction

    task automatic new_bundle(input int r);
        for (int w = 0; w < NW; w++) rq_b[r][w] = $urandom;
        act[r] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid_i   = '0;
        resp_ready_i  = '0;
        unit_done_i   = 1'b0;
        unit_result_i = '0;
        for (int r = 0; r < NR; r++) act[r] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_busy = 1'b0; m_rr = NR - 1; m_free = cyc; m_bundle = '0; m_tcnt = 0;
        stray = 1'b0; prev_rv = 1'b0;
        dut_log.delete();
    endtask

    // One clock cycle: entered at posedge+1, drives inputs, checks at negedge.
    task automatic step();
        bit [NR-1:0] v, exp_ready, exp_rv;
        bit          granted;
        int          g, bad;
        for (int r = 0; r < NR; r++)
            if (!act[r] && arm_mask[r] && $urandom_range(0, 99) < arm_pct) new_bundle(r);
        for (int r = 0; r < NR; r++) begin
            v[r]            = act[r];
            req_regs_i[r]   = rq_b[r];
            resp_ready_i[r] = ($urandom_range(0, 99) < rdy_pct);
        end
        req_valid_i = v;
        if (m_busy && m_L < TO && cyc == m_T + 2 + m_L) begin
            unit_done_i   = 1'b1;
            unit_result_i = unit_fn(m_bundle);
        end else begin
            unit_done_i   = stray;
            unit_result_i = $urandom;
        end
        stray = 1'b0;
        #4;
        bad = 0;
        for (int w = NW - 1; w >= 0; w--) if (unit_regs_o[w] !== m_bundle[w]) bad = w;
        chk($sformatf("unit_regs[%0d]", bad), unit_regs_o[bad], m_bundle[bad]);
        exp_ready = '0;
        granted   = 1'b0;
        g         = 0;
        if (!m_busy && cyc >= m_free && v != '0) begin
            for (int k = 1; k <= NR; k++)
                if (!granted && v[(m_rr + k) % NR]) begin
                    granted = 1'b1;
                    g = (m_rr + k) % NR;
                end
            exp_ready[g] = 1'b1;
            m_busy = 1'b1; m_g = g; m_T = cyc; m_L = pick_lat(); m_bundle = rq_b[g];
            act[g] = 1'b0;
            m_err  = (m_L >= TO);
            m_R    = m_err ? cyc + 2 + TO : cyc + 3 + m_L;
            m_data = m_err ? 32'hFFFF_FFFF : unit_fn(m_bundle);
        end
        if (m_busy && cyc == m_R && m_err && m_tcnt < 65535) m_tcnt++;
        chk("req_ready", req_ready_o, exp_ready);
        chk("unit_valid", unit_valid_o, m_busy && cyc == m_T + 1);
        chk("busy", busy_o, m_busy && cyc > m_T);
        chk("timeout_cnt", timeout_cnt_o, m_tcnt);
        exp_rv = '0;
        if (m_busy && cyc >= m_R) exp_rv[m_g] = 1'b1;
        chk("resp_valid", resp_valid_o, exp_rv);
        if (exp_rv != '0) begin
            chk("resp_data", resp_data_o, m_data);
            chk("resp_err", resp_err_o, m_err);
        end
        for (int r = 0; r < NR; r++)
            if (req_ready_o[r]) begin
                dut_log.push_back(r);
                dut_acc_cyc = cyc;
            end
        if (resp_valid_o != '0 && !prev_rv) dut_resp_cyc = cyc;
        prev_rv = (resp_valid_o != '0);
        if (m_busy && cyc >= m_R && resp_ready_i[m_g]) begin
            m_busy = 1'b0; m_rr = m_g; m_free = cyc + 1; n_txn++;
        end
        @(posedge clk);
        #1 cyc++;
    endtask

    task automatic run_txns(input int n, input int bound);
        int start, k;
        start = n_txn;
        k = 0;
        while (n_txn < start + n && k < bound) begin
            step();
            k++;
        end
        if (k >= bound) chk("txn_count_bound", n_txn - start, n);
    endtask

    task automatic drain();
        int k;
        arm_pct = 0; rdy_pct = 100; k = 0;
        while ((m_busy || any_act()) && k < 500) begin
            step();
            k++;
        end
        chk("drain_idle", busy_o, 1'b0);
    endtask

    initial begin
        cyc = 0; n_txn = 0; arm_mask = '0; arm_pct = 0; rdy_pct = 100; lat_force = 2;
        req_regs_i = '0;
        for (int r = 0; r < NR; r++) rq_b[r] = '0;
        do_reset();

        #3;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_resp_valid", resp_valid_o, '0);
        chk("rst_unit_valid", unit_valid_o, 1'b0);
        chk("rst_req_ready", req_ready_o, '0);
        chk("rst_resp_data", resp_data_o, '0);
        chk("rst_resp_err", resp_err_o, 1'b0);
        chk("rst_timeout_cnt", timeout_cnt_o, '0);
        chk("rst_unit_regs0", unit_regs_o[0], '0);
        @(posedge clk);
        #1;

        // Single request from requester 1, unit latency 4.
        lat_force = 4;
        new_bundle(1);
        run_txns(1, 50);
        chk("single_grant", dut_log.size() > 0 ? dut_log[0] : -1, 1);
        chk("single_latency", dut_resp_cyc - dut_acc_cyc, 7);

        // Fairness from reset: all requesters continuously valid.
        do_reset();
        lat_force = 1; arm_mask = 3'b111; arm_pct = 100; rdy_pct = 100;
        run_txns(6, 200);
        for (int i = 0; i < 6; i++)
            chk($sformatf("fair_order[%0d]", i), (i < dut_log.size()) ? dut_log[i] : -1, i % NR);
        drain();

        // Backpressure: hold the response 10 cycles with everyone waiting.
        begin
            int k;
            lat_force = 3; arm_pct = 100; rdy_pct = 0; k = 0;
            while (!(m_busy && cyc >= m_R + 10) && k < 100) begin
                step();
                k++;
            end
            chk("bp_resp_held", resp_valid_o != '0, 1'b1);
        end
        drain();

        // Watchdog timeout, a stray done in IDLE, then a normal request.
        arm_mask = '0; lat_force = NEVER;
        new_bundle(2);
        run_txns(1, 200);
        chk("timeout_cnt_after", timeout_cnt_o, 16'd1);
        stray = 1'b1;
        step();
        step();
        lat_force = 2;
        new_bundle(0);
        run_txns(1, 50);

        // Reset asserted while the unit is busy.
        lat_force = NEVER;
        new_bundle(1);
        begin
            int k;
            k = 0;
            while (!(m_busy && cyc == m_T + 4) && k < 50) begin
                step();
                k++;
            end
        end
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_resp_valid", resp_valid_o, '0);
        chk("midrst_unit_valid", unit_valid_o, 1'b0);
        do_reset();
        lat_force = 2;
        new_bundle(0);
        run_txns(1, 50);
        chk("post_reset_grant", dut_log.size() > 0 ? dut_log[0] : -1, 0);

        // Random traffic against the reference model.
        lat_force = -1; arm_mask = 3'b111; arm_pct = 30; rdy_pct = 60;
        run_txns(100, 20000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
